// File: rtl/serial_uart_bridge_pkg.sv
// -----------------------------------------------------------------------------
// serial_uart_bridge_pkg
// Shared definitions for the serial UART bridge: line idle level, default
// timing/depth parameters and the TX/RX state encodings.
// Ports: none (package).
// -----------------------------------------------------------------------------
package serial_uart_bridge_pkg;

   localparam logic UART_IDLE            = 1'b1;
   localparam int   DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud
   localparam int   DEFAULT_FIFO_DEPTH   = 16;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

endpackage

// File: rtl/serial_uart_bridge_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// 8-bit first-word fall-through FIFO. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter register.
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high; empties the FIFO
//   push       in   write push_data (ignored when full unless popping too)
//   push_data  in   8-bit byte to store
//   pop        in   drop the head entry (ignored when empty)
//   head       out  current head entry, 8'h00 when empty
//   full       out  DEPTH entries held
//   empty      out  no entries held
// -----------------------------------------------------------------------------
module byte_fifo
   import serial_uart_bridge_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);

   localparam int         AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] count;
   logic        pop_ok;
   logic        push_ok;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_ok  = pop & ~empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_ok = push & (~full | pop_ok);

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // NOTE: the storage array has no reset; only the pointers define which
   // entries are valid, and leaving it unreset lets it map onto RAM.
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/serial_uart_bridge.sv
// -----------------------------------------------------------------------------
// serial_uart_bridge
// Connects data_memory's memory-mapped serial port to the board UART pins.
// Processor bytes are queued in a TX FIFO and sent as 8N1 frames; received
// 8N1 frames are queued in an RX FIFO for the processor to read.
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous, active-high
//   serial_out       in   byte from data_memory to transmit
//   serial_wren_out  in   push serial_out into the TX FIFO
//   serial_rden_out  in   pop the head of the RX FIFO
//   serial_in        out  head of the RX FIFO (first-word fall-through)
//   serial_valid_in  out  RX FIFO not empty
//   serial_ready_in  out  TX FIFO not full
//   uart_rxd         in   asynchronous serial line in, idles high
//   uart_txd         out  serial line out, idles high
//   status_clear     in   clears the sticky flags
//   rx_overflow      out  sticky: received byte dropped on a full RX FIFO
//   frame_error      out  sticky: stop bit sampled low
// -----------------------------------------------------------------------------
module serial_uart_bridge
   import serial_uart_bridge_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] serial_out,
   input  logic       serial_wren_out,
   input  logic       serial_rden_out,
   output logic [7:0] serial_in,
   output logic       serial_valid_in,
   output logic       serial_ready_in,
   input  logic       uart_rxd,
   output logic       uart_txd,
   input  logic       status_clear,
   output logic       rx_overflow,
   output logic       frame_error
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   // ---------------------------------------------------------------- FIFOs
   logic [7:0] tx_head;
   logic       tx_full;
   logic       tx_empty;
   logic       tx_pop;
   logic [7:0] rx_shift;
   logic       rx_push;
   logic       rx_full;
   logic       rx_empty;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) tx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (serial_wren_out & ~tx_full),
      .push_data (serial_out),
      .pop       (tx_pop),
      .head      (tx_head),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   byte_fifo #(.DEPTH(FIFO_DEPTH)) rx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (rx_push),
      .push_data (rx_shift),
      .pop       (serial_rden_out),
      .head      (serial_in),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   assign serial_ready_in = ~tx_full;
   assign serial_valid_in = ~rx_empty;

   // ---------------------------------------------------------------- TX FSM
   tx_state_t     tx_state;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift;

   assign tx_pop = (tx_state == TX_IDLE) & ~tx_empty;

   // The line level is registered from the state of the previous cycle, so the
   // start bit appears two edges after the push and the pin is a clean flop.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         uart_txd <= UART_IDLE;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               uart_txd <= UART_IDLE;
               if (!tx_empty) begin
                  tx_shift <= tx_head;
                  tx_cnt   <= BIT_LAST;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               uart_txd <= 1'b0;
               if (tx_cnt == '0) begin
                  tx_cnt   <= BIT_LAST;
                  tx_bit   <= '0;
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt - CNT_ONE;
               end
            end
            TX_DATA: begin
               uart_txd <= tx_shift[0];
               if (tx_cnt == '0) begin
                  tx_cnt   <= BIT_LAST;
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  if (tx_bit == 3'd7) tx_state <= TX_STOP;
                  else                tx_bit   <= tx_bit + 3'd1;
               end else begin
                  tx_cnt <= tx_cnt - CNT_ONE;
               end
            end
            TX_STOP: begin
               uart_txd <= UART_IDLE;
               if (tx_cnt == '0) tx_state <= TX_IDLE;
               else              tx_cnt   <= tx_cnt - CNT_ONE;
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- RX FSM
   rx_state_t     rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [1:0]    rx_sync;
   logic          rxs;
   logic          stop_sample;

   // Two-flop synchronizer; reset to the idle level so no false start follows reset.
   always_ff @(posedge clock) begin
      if (reset) rx_sync <= {2{UART_IDLE}};
      else       rx_sync <= {rx_sync[0], uart_rxd};
   end

   assign rxs         = rx_sync[1];
   assign stop_sample = (rx_state == RX_STOP) & (rx_cnt == '0);
   assign rx_push     = stop_sample & rxs;

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               if (!rxs) begin
                  rx_cnt   <= HALF_LAST;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt == '0) begin
                  // Start bit still low at mid-bit: real frame, else a glitch.
                  if (!rxs) begin
                     rx_cnt   <= BIT_LAST;
                     rx_bit   <= '0;
                     rx_state <= RX_DATA;
                  end else begin
                     rx_state <= RX_IDLE;
                  end
               end else begin
                  rx_cnt <= rx_cnt - CNT_ONE;
               end
            end
            RX_DATA: begin
               if (rx_cnt == '0) begin
                  rx_cnt   <= BIT_LAST;
                  rx_shift <= {rxs, rx_shift[7:1]};
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
                  else                rx_bit   <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt - CNT_ONE;
               end
            end
            RX_STOP: begin
               if (rx_cnt == '0) rx_state <= rxs ? RX_IDLE : RX_WAIT_HIGH;
               else              rx_cnt   <= rx_cnt - CNT_ONE;
            end
            RX_WAIT_HIGH: begin
               if (rxs) rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- flags
   // Setting wins over status_clear so an event in the clear cycle is kept.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_overflow <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         if (rx_push & rx_full & ~serial_rden_out) rx_overflow <= 1'b1;
         else if (status_clear)                    rx_overflow <= 1'b0;
         if (stop_sample & ~rxs)  frame_error <= 1'b1;
         else if (status_clear)   frame_error <= 1'b0;
      end
   end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// -----------------------------------------------------------------------------
// tb_serial_uart_bridge
// Directed bench for serial_uart_bridge with CLKS_PER_BIT=8, FIFO_DEPTH=4.
// A timeline model of the transmitter and a queue model of the receiver are
// compared against the DUT every cycle; literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_serial_uart_bridge;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] serial_out = 8'h00;
   logic       serial_wren_out = 1'b0;
   logic       serial_rden_out = 1'b0;
   logic [7:0] serial_in;
   logic       serial_valid_in;
   logic       serial_ready_in;
   logic       uart_rxd = 1'b1;
   logic       uart_txd;
   logic       status_clear = 1'b0;
   logic       rx_overflow;
   logic       frame_error;

   serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clock           (clock),
      .reset           (reset),
      .serial_out      (serial_out),
      .serial_wren_out (serial_wren_out),
      .serial_rden_out (serial_rden_out),
      .serial_in       (serial_in),
      .serial_valid_in (serial_valid_in),
      .serial_ready_in (serial_ready_in),
      .uart_rxd        (uart_rxd),
      .uart_txd        (uart_txd),
      .status_clear    (status_clear),
      .rx_overflow     (rx_overflow),
      .frame_error     (frame_error)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------ TX model
   // A byte is taken from the queue on the first edge the transmitter is free;
   // the line then shows start, 8 data bits LSB first and stop, CPB cycles each,
   // starting one edge after the take. The transmitter is free again 81 edges
   // after a take.
   logic [7:0] mq [$];
   logic [7:0] m_byte = 8'h00;
   int         m_edge = 0;
   int         m_pop  = 0;
   bit         m_act  = 1'b0;
   logic       m_txd  = 1'b1;
   logic       m_ready = 1'b1;

   always @(posedge clock) begin
      int sz;
      int d;
      int k;
      m_edge++;
      if (reset) begin
         mq.delete();
         m_act   = 1'b0;
         m_txd   = 1'b1;
         m_ready = 1'b1;
      end else begin
         sz = mq.size();
         if (sz > 0 && (!m_act || (m_edge - m_pop) > FRAME)) begin
            m_byte = mq.pop_front();
            m_pop  = m_edge;
            m_act  = 1'b1;
         end
         if (serial_wren_out && sz < DEPTH) mq.push_back(serial_out);
         d = m_edge - m_pop;
         if (m_act && d >= 1 && d <= FRAME) begin
            k = (d - 1) / CPB;
            if (k == 0)      m_txd = 1'b0;
            else if (k == 9) m_txd = 1'b1;
            else             m_txd = m_byte[k-1];
         end else begin
            m_txd = 1'b1;
         end
         m_ready = (mq.size() < DEPTH);
      end
   end

   // ------------------------------------------------------------ RX model
   logic [7:0] rq [$];
   bit         m_ovf   = 1'b0;
   bit         m_fe    = 1'b0;
   bit         rx_busy = 1'b0;
   bit         chk_en  = 1'b0;

   always @(negedge clock) begin
      if (chk_en) begin
         check("txd", uart_txd, m_txd);
         check("ready", serial_ready_in, m_ready);
         if (!rx_busy) begin
            check("valid", serial_valid_in, rq.size() != 0);
            check("rx_data", serial_in, (rq.size() != 0) ? rq[0] : 8'h00);
            check("overflow", rx_overflow, m_ovf);
            check("frame_err", frame_error, m_fe);
         end
      end
   end

   // ------------------------------------------------------------ helpers
   task automatic at_neg(input int m);
      while (cyc < m) begin
         @(posedge clock);
         #1;
      end
      @(negedge clock);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input bit stop_hi);
      logic [9:0] f;
      f = {stop_hi, b, 1'b0};
      rx_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         uart_rxd = f[i];
         tick(CPB);
      end
      if (stop_hi) begin
         if (rq.size() < DEPTH) rq.push_back(b);
         else                   m_ovf = 1'b1;
      end else begin
         m_fe = 1'b1;
      end
      rx_busy = 1'b0;
   endtask

   task automatic read_byte();
      serial_rden_out = 1'b1;
      tick(1);
      serial_rden_out = 1'b0;
      if (rq.size() > 0) rq.delete(0);
   endtask

   task automatic clear_status();
      status_clear = 1'b1;
      tick(1);
      status_clear = 1'b0;
      m_ovf = 1'b0;
      m_fe  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "time limit");
   end

   logic [9:0] t1_frame = 10'b1_1010_0101_0;
   logic [7:0] rx4 [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      int n;
      tick(3);
      reset  = 1'b0;
      chk_en = 1'b1;

      // Reset state
      @(negedge clock);
      check("rst_txd", uart_txd, 1'b1);
      check("rst_valid", serial_valid_in, 1'b0);
      check("rst_data", serial_in, 8'h00);
      check("rst_ready", serial_ready_in, 1'b1);
      check("rst_ovf", rx_overflow, 1'b0);
      check("rst_ferr", frame_error, 1'b0);

      // 1. single TX frame 8'hA5
      tick(1);
      serial_out      = 8'hA5;
      serial_wren_out = 1'b1;
      tick(1);
      serial_wren_out = 1'b0;
      n = cyc;
      at_neg(n + 1);
      check("t1_latency_hi", uart_txd, 1'b1);
      for (int b = 0; b < 9; b++) begin
         at_neg(n + 2 + CPB * b + CPB / 2);
         check("t1_bit", uart_txd, t1_frame[b]);
      end

      // 2. five back-to-back writes while the first frame is still on the line
      for (int i = 0; i < 5; i++) begin
         serial_out      = 8'h10 + 8'(i);
         serial_wren_out = 1'b1;
         tick(1);
         if (i == 2) check("t2_ready_3rd", serial_ready_in, 1'b1);
         if (i == 3) check("t2_ready_4th", serial_ready_in, 1'b0);
      end
      serial_wren_out = 1'b0;
      at_neg(n + 2 + CPB * 9 + CPB / 2);
      check("t1_stop", uart_txd, 1'b1);
      at_neg(n + 82);
      check("t2_idle_gap", uart_txd, 1'b1);
      at_neg(n + 83);
      check("t2_next_start", uart_txd, 1'b0);
      at_neg(n + 83 + 3 * 81 + FRAME + 5);
      check("t2_done_txd", uart_txd, 1'b1);
      check("t2_done_ready", serial_ready_in, 1'b1);

      // 3. receive 8'h3C
      send_rx(8'h3C, 1'b1);
      @(negedge clock);
      check("t3_valid", serial_valid_in, 1'b1);
      check("t3_data", serial_in, 8'h3C);
      read_byte();
      @(negedge clock);
      check("t3_empty", serial_valid_in, 1'b0);

      // 4. five frames, no reads
      for (int i = 0; i < 5; i++) begin
         send_rx(8'h11 * 8'(i + 1), 1'b1);
         tick(2);
      end
      @(negedge clock);
      check("t4_valid", serial_valid_in, 1'b1);
      check("t4_head", serial_in, 8'h11);
      check("t4_ovf", rx_overflow, 1'b1);
      clear_status();
      @(negedge clock);
      check("t4_ovf_clr", rx_overflow, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("t4_order", serial_in, rx4[i]);
         read_byte();
      end
      @(negedge clock);
      check("t4_drained", serial_valid_in, 1'b0);

      // 5. bad stop bit followed by a held break, then a good frame
      send_rx(8'hF0, 1'b0);
      tick(40);
      @(negedge clock);
      check("t5_ferr", frame_error, 1'b1);
      check("t5_no_push", serial_valid_in, 1'b0);
      uart_rxd = 1'b1;
      tick(5);
      send_rx(8'h01, 1'b1);
      @(negedge clock);
      check("t5_valid", serial_valid_in, 1'b1);
      check("t5_data", serial_in, 8'h01);
      clear_status();
      @(negedge clock);
      check("t5_ferr_clr", frame_error, 1'b0);

      // 6. short glitch, then reset in the middle of a TX frame
      uart_rxd = 1'b0;
      tick(2);
      uart_rxd = 1'b1;
      tick(20);
      @(negedge clock);
      check("t6_glitch_data", serial_in, 8'h01);
      check("t6_glitch_ovf", rx_overflow, 1'b0);
      check("t6_glitch_ferr", frame_error, 1'b0);
      serial_out      = 8'h5A;
      serial_wren_out = 1'b1;
      tick(1);
      serial_wren_out = 1'b0;
      tick(30);
      reset = 1'b1;
      tick(1);
      rq.delete();
      m_ovf = 1'b0;
      m_fe  = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      check("t6_rst_txd", uart_txd, 1'b1);
      check("t6_rst_valid", serial_valid_in, 1'b0);
      check("t6_rst_ready", serial_ready_in, 1'b1);
      tick(100);
      @(negedge clock);
      check("t6_idle_txd", uart_txd, 1'b1);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
